// File: rtl/microseq_pkg.sv
// Shared types for the microprogrammed sequencer: microword opcodes, FSM states,
// field-layout helpers and a default-width microword struct.
package microseq_pkg;

  localparam int OP_W = 3;

  localparam int DEF_UADDR_W = 8;
  localparam int DEF_OPC_W   = 8;
  localparam int DEF_CTRL_W  = 29;
  localparam int DEF_COND_W  = 4;
  localparam int DEF_CSEL_W  = $clog2(DEF_COND_W);

  typedef enum logic [OP_W-1:0] {
    OP_SEQ      = 3'd0,
    OP_JMP      = 3'd1,
    OP_BRT      = 3'd2,
    OP_BRF      = 3'd3,
    OP_CALL     = 3'd4,
    OP_RET      = 3'd5,
    OP_DISPATCH = 3'd6,
    OP_HALT     = 3'd7
  } uop_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  // Field offsets, LSB first: ctrl | op | csel | target
  function automatic int op_lsb(int ctrl_w);
    return ctrl_w;
  endfunction

  function automatic int csel_lsb(int ctrl_w);
    return ctrl_w + OP_W;
  endfunction

  function automatic int target_lsb(int ctrl_w, int csel_w);
    return ctrl_w + OP_W + csel_w;
  endfunction

  function automatic int uword_width(int ctrl_w, int csel_w, int uaddr_w);
    return ctrl_w + OP_W + csel_w + uaddr_w;
  endfunction

  typedef struct packed {
    logic [DEF_UADDR_W-1:0] target;
    logic [DEF_CSEL_W-1:0]  csel;
    uop_e                   op;
    logic [DEF_CTRL_W-1:0]  ctrl;
  } uword_t;

endpackage

// File: rtl/microseq_if.sv
// Sequencer bus: instruction handshake, control-store and map-ROM ports, and
// datapath-facing outputs. master = sequencer, slave = surrounding system.
interface microseq_if
  import microseq_pkg::*;
#(
  parameter int UADDR_W = 8,
  parameter int OPC_W   = 8,
  parameter int CTRL_W  = 29,
  parameter int COND_W  = 4,
  parameter int UW_W    = uword_width(CTRL_W, $clog2(COND_W), UADDR_W)
);
  logic [OPC_W-1:0]   instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [COND_W-1:0]  cond_in;
  logic               stall;
  logic [UADDR_W-1:0] ustore_addr;
  logic [UW_W-1:0]    ustore_data;
  logic [OPC_W-1:0]   map_addr;
  logic [UADDR_W-1:0] map_data;
  logic [CTRL_W-1:0]  ctrl_signals;
  logic [OPC_W-1:0]   ir;
  logic               eoi;
  logic               halted;
  logic               fault;

  modport master (
    input  instr, instr_valid, cond_in, stall, ustore_data, map_data,
    output instr_ready, ustore_addr, map_addr, ctrl_signals, ir, eoi, halted, fault
  );

  modport slave (
    output instr, instr_valid, cond_in, stall, ustore_data, map_data,
    input  instr_ready, ustore_addr, map_addr, ctrl_signals, ir, eoi, halted, fault
  );
endinterface

// File: rtl/microseq_stack.sv
// Microsubroutine return stack: small LIFO with combinational top-of-stack so
// a RET can redirect the sequencer in a single cycle.
module microseq_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = ptr_reg[IDX_W-1:0];
  assign rd_idx = IDX_W'(ptr_reg - 1'b1);
  assign full   = (ptr_reg == PTR_W'(DEPTH));
  assign empty  = (ptr_reg == '0);
  assign top    = mem[rd_idx];

  // Entries need no reset: the pointer alone defines what is valid
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (push && !full) begin
      ptr_reg <= ptr_reg + 1'b1;
    end else if (pop && !empty) begin
      ptr_reg <= ptr_reg - 1'b1;
    end
  end
endmodule

// File: rtl/microseq_ctrl.sv
// Microprogrammed sequencer: next-address selection, RUN/HALTED/FAULT FSM,
// opcode dispatch handshake and datapath control gating.
module microseq_ctrl
  import microseq_pkg::*;
#(
  parameter int                 UADDR_W     = 8,
  parameter int                 OPC_W       = 8,
  parameter int                 CTRL_W      = 29,
  parameter int                 COND_W      = 4,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [UADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic     clk,
  input  logic     rst_n,
  microseq_if.master bus
);
  localparam int CSEL_W   = $clog2(COND_W);
  localparam int OP_LSB   = op_lsb(CTRL_W);
  localparam int CSEL_LSB = csel_lsb(CTRL_W);
  localparam int TGT_LSB  = target_lsb(CTRL_W, CSEL_W);

  logic [UADDR_W-1:0] upc_reg;
  logic [OPC_W-1:0]   ir_reg;
  state_e             state_reg;

  logic [CTRL_W-1:0]  uw_ctrl;
  uop_e               uw_op;
  logic [CSEL_W-1:0]  uw_csel;
  logic [UADDR_W-1:0] uw_target;
  logic [UADDR_W-1:0] upc_inc;
  logic               cond_bit;
  logic               run;
  logic               active;
  logic               ctrl_en;
  logic               dispatch_fire;
  logic               stk_push;
  logic               stk_pop;
  logic               stk_full;
  logic               stk_empty;
  logic [UADDR_W-1:0] stk_top;

  assign uw_ctrl   = bus.ustore_data[CTRL_W-1:0];
  assign uw_op     = uop_e'(bus.ustore_data[OP_LSB +: OP_W]);
  assign uw_csel   = bus.ustore_data[CSEL_LSB +: CSEL_W];
  assign uw_target = bus.ustore_data[TGT_LSB +: UADDR_W];
  assign upc_inc   = upc_reg + 1'b1;
  assign cond_bit  = bus.cond_in[uw_csel];

  assign run    = (state_reg == ST_RUN);
  assign active = run && !bus.stall;

  // Gated by rst_n so that nothing leaks out while reset is held
  assign bus.instr_ready = rst_n && active && (uw_op == OP_DISPATCH);
  assign dispatch_fire   = bus.instr_valid && bus.instr_ready;
  assign ctrl_en         = rst_n && active && !((uw_op == OP_DISPATCH) && !bus.instr_valid);

  assign bus.ustore_addr  = upc_reg;
  assign bus.map_addr     = bus.instr;
  assign bus.ctrl_signals = ctrl_en ? uw_ctrl : '0;
  assign bus.ir           = ir_reg;
  assign bus.eoi          = dispatch_fire;
  assign bus.halted       = (state_reg == ST_HALTED);
  assign bus.fault        = (state_reg == ST_FAULT);

  assign stk_push = active && (uw_op == OP_CALL) && !stk_full;
  assign stk_pop  = active && (uw_op == OP_RET) && !stk_empty;

  microseq_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (UADDR_W)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (upc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_reg   <= RESET_ADDR;
      ir_reg    <= '0;
      state_reg <= ST_RUN;
    end else if (active) begin
      unique case (uw_op)
        OP_SEQ:  upc_reg <= upc_inc;
        OP_JMP:  upc_reg <= uw_target;
        OP_BRT:  upc_reg <= cond_bit ? uw_target : upc_inc;
        OP_BRF:  upc_reg <= cond_bit ? upc_inc : uw_target;
        OP_CALL: begin
          if (stk_full) state_reg <= ST_FAULT;
          else          upc_reg   <= uw_target;
        end
        OP_RET: begin
          if (stk_empty) state_reg <= ST_FAULT;
          else           upc_reg   <= stk_top;
        end
        OP_DISPATCH: begin
          if (bus.instr_valid) begin
            ir_reg  <= bus.instr;
            upc_reg <= bus.map_data;
          end
        end
        OP_HALT: state_reg <= ST_HALTED;
        default: upc_reg <= upc_inc;
      endcase
    end
  end
endmodule

// File: tb/tb_microseq_ctrl.sv
// Directed bench for microseq_ctrl: a cycle table for the main program plus
// hand sequences for fault, stall-on-full, reset-mid-call, wrap and halt.
module tb_microseq_ctrl;
  localparam int UADDR_W = 8;
  localparam int OPC_W   = 8;
  localparam int CTRL_W  = 29;
  localparam int COND_W  = 4;
  localparam int UW_W    = CTRL_W + 3 + 2 + UADDR_W;

  localparam int SEQ = 0, JMP = 1, BRT = 2, BRF = 3, CALL = 4, RET = 5, DISP = 6, HALT = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [UW_W-1:0]    ustore [256];
  logic [UADDR_W-1:0] maprom [256];

  microseq_if #(.UADDR_W(UADDR_W), .OPC_W(OPC_W), .CTRL_W(CTRL_W), .COND_W(COND_W)) bus ();

  microseq_ctrl #(
    .UADDR_W(UADDR_W), .OPC_W(OPC_W), .CTRL_W(CTRL_W), .COND_W(COND_W),
    .STACK_DEPTH(4), .RESET_ADDR(8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.ustore_data = ustore[bus.ustore_addr];
  assign bus.map_data    = maprom[bus.map_addr];

  typedef struct {
    logic [7:0] instr;
    logic       valid;
    logic [3:0] cond;
    logic       stall;
    logic [7:0] addr;
    logic       ctrl_on;
    logic       rdy;
    logic       eoi;
    logic [7:0] ir;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [CTRL_W-1:0] ctrl_of(input logic [7:0] a);
    return {a, 21'h15A3C};
  endfunction

  task automatic put(input logic [7:0] a, input int op, input logic [1:0] csel, input logic [7:0] tgt);
    logic [2:0] op3;
    op3 = 3'(op);
    ustore[a] = {tgt, csel, op3, ctrl_of(a)};
  endtask

  function automatic vec_t mkv(input logic [7:0] instr, input logic valid, input logic [3:0] cond,
                               input logic stall, input logic [7:0] addr, input logic ctrl_on,
                               input logic rdy, input logic eoi, input logic [7:0] ir);
    vec_t v;
    v.instr = instr; v.valid = valid; v.cond = cond; v.stall = stall;
    v.addr = addr; v.ctrl_on = ctrl_on; v.rdy = rdy; v.eoi = eoi; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] addr, input logic [CTRL_W-1:0] ctrl,
                           input logic rdy, input logic eoi, input logic [7:0] ir,
                           input logic halted, input logic fault);
    chk({tag, ".addr"},   64'(bus.ustore_addr),  64'(addr));
    chk({tag, ".ctrl"},   64'(bus.ctrl_signals), 64'(ctrl));
    chk({tag, ".ready"},  64'(bus.instr_ready),  64'(rdy));
    chk({tag, ".eoi"},    64'(bus.eoi),          64'(eoi));
    chk({tag, ".ir"},     64'(bus.ir),           64'(ir));
    chk({tag, ".halted"}, 64'(bus.halted),       64'(halted));
    chk({tag, ".fault"},  64'(bus.fault),        64'(fault));
    $display("[%0t] %s addr=%02h ctrl=%08h rdy=%0b eoi=%0b ir=%02h halted=%0b fault=%0b",
             $time, tag, bus.ustore_addr, bus.ctrl_signals, bus.instr_ready, bus.eoi,
             bus.ir, bus.halted, bus.fault);
  endtask

  task automatic drive(input logic [7:0] instr, input logic valid, input logic [3:0] cond, input logic stall);
    bus.instr = instr; bus.instr_valid = valid; bus.cond_in = cond; bus.stall = stall;
  endtask

  task automatic idle();
    drive(8'h00, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ustore[i] = '0;
      maprom[i] = '0;
    end
    put(8'h00, SEQ, 2'd0, 8'h00);
    put(8'h01, SEQ, 2'd0, 8'h00);
    put(8'h02, JMP, 2'd0, 8'h10);
    put(8'h10, BRT, 2'd2, 8'h30);
    put(8'h30, BRT, 2'd2, 8'h40);
    put(8'h31, BRF, 2'd2, 8'h50);
    put(8'h32, BRF, 2'd2, 8'h34);
    put(8'h34, JMP, 2'd0, 8'h20);
    put(8'h20, DISP, 2'd0, 8'h00);
    put(8'h60, CALL, 2'd0, 8'h70);
    put(8'h70, CALL, 2'd0, 8'h80);
    put(8'h80, CALL, 2'd0, 8'h90);
    put(8'h90, CALL, 2'd0, 8'hA0);
    put(8'hA0, RET, 2'd0, 8'h00);
    put(8'h91, RET, 2'd0, 8'h00);
    put(8'h81, RET, 2'd0, 8'h00);
    put(8'h71, RET, 2'd0, 8'h00);
    put(8'h61, JMP, 2'd0, 8'hFE);
    put(8'hFE, SEQ, 2'd0, 8'h00);
    put(8'hFF, CALL, 2'd0, 8'hC0);
    put(8'hC0, DISP, 2'd0, 8'h00);
    put(8'hC1, DISP, 2'd0, 8'h00);
    put(8'hC2, RET, 2'd0, 8'h00);
    maprom[8'h5A] = 8'h60;
    maprom[8'h33] = 8'hC1;
    maprom[8'h44] = 8'hC2;

    //                instr  v     cond  st    addr   on    rdy   eoi   ir
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h4, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h4, 1'b0, 8'h31, 1'b1, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h32, 1'b1, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h34, 1'b1, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00));
    vecs.push_back(mkv(8'hEE, 1'b1, 4'h0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mkv(8'h5A, 1'b1, 4'h0, 1'b0, 8'h20, 1'b1, 1'b1, 1'b1, 8'h00));
    vecs.push_back(mkv(8'h77, 1'b1, 4'h0, 1'b0, 8'h60, 1'b1, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h70, 1'b1, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h99, 1'b1, 4'h0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h90, 1'b1, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h91, 1'b1, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h71, 1'b1, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h61, 1'b1, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h5A));
    vecs.push_back(mkv(8'h33, 1'b1, 4'h0, 1'b0, 8'hC0, 1'b1, 1'b1, 1'b1, 8'h5A));
    vecs.push_back(mkv(8'h44, 1'b1, 4'h0, 1'b0, 8'hC1, 1'b1, 1'b1, 1'b1, 8'h33));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'hC2, 1'b1, 1'b0, 1'b0, 8'h44));
    vecs.push_back(mkv(8'h00, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h44));

    // Reset state
    idle();
    repeat (2) @(negedge clk);
    #1 check_all("reset", 8'h00, '0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main program table
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].valid, vecs[i].cond, vecs[i].stall);
      #1 check_all($sformatf("row%0d", i), vecs[i].addr,
                   vecs[i].ctrl_on ? ctrl_of(vecs[i].addr) : '0,
                   vecs[i].rdy, vecs[i].eoi, vecs[i].ir, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Fifth nested CALL faults; stalling on a full stack defers the fault
    idle();
    rst_n = 1'b0;
    put(8'h00, CALL, 2'd0, 8'hD0);
    put(8'hD0, CALL, 2'd0, 8'hD1);
    put(8'hD1, CALL, 2'd0, 8'hD2);
    put(8'hD2, CALL, 2'd0, 8'hD3);
    put(8'hD3, CALL, 2'd0, 8'hD4);
    #1 check_all("rst2", 8'h00, '0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all("call1", 8'h00, ctrl_of(8'h00), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1 check_all("call2", 8'hD0, ctrl_of(8'hD0), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1 check_all("call3", 8'hD1, ctrl_of(8'hD1), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1 check_all("call4", 8'hD2, ctrl_of(8'hD2), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    bus.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1 check_all($sformatf("fullstall%0d", k), 8'hD3, '0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
    end
    bus.stall = 1'b0;
    #1 check_all("call5", 8'hD3, ctrl_of(8'hD3), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1 check_all($sformatf("fault%0d", k), 8'hD3, '0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
    end

    // Reset mid-call discards stack: a RET right after reset must fault
    rst_n = 1'b0;
    #1 check_all("rst3", 8'h00, '0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_all("midcall", 8'hD2, ctrl_of(8'hD2), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all("asyncrst", 8'h00, '0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    put(8'h00, RET, 2'd0, 8'h00);
    rst_n = 1'b1;
    #1 check_all("ret_empty", 8'h00, ctrl_of(8'h00), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1 check_all("ret_fault", 8'h00, '0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);

    // SEQ at 0xFF wraps to 0, then HALT
    rst_n = 1'b0;
    put(8'h00, JMP, 2'd0, 8'hFF);
    put(8'hFF, SEQ, 2'd0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all("jmpff", 8'h00, ctrl_of(8'h00), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1 check_all("seqff", 8'hFF, ctrl_of(8'hFF), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    put(8'h00, HALT, 2'd0, 8'h00);
    @(negedge clk);
    drive(8'h5A, 1'b1, 4'h0, 1'b0);
    #1 check_all("wrap_halt", 8'h00, ctrl_of(8'h00), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      #1 check_all($sformatf("halted%0d", k), 8'h00, '0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
